// File: rtl/exec_unit.sv
// Execution unit: WIDTH-bit W register, carry/zero flags, ALU with valid/ready handshake.
// Define EXEC_UNIT_MUL_EN to build the shift-add multiplier (opcode 12) and the H register.
module exec_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       inst,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] h,
    output logic             carry,
    output logic             zero
);

    localparam logic [3:0] OpLoad = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpNot  = 4'd6;
    localparam logic [3:0] OpShl  = 4'd7;
    localparam logic [3:0] OpShr  = 4'd8;
    localparam logic [3:0] OpAdc  = 4'd9;
    localparam logic [3:0] OpInc  = 4'd10;
    localparam logic [3:0] OpDec  = 4'd11;
    localparam logic [3:0] OpClrc = 4'd13;

    logic [WIDTH-1:0] w_q, w_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_w;
    logic             alu_c;
    logic             alu_wr;
    logic             single_acc;

    logic [WIDTH:0] add_full, adc_full, sub_full, inc_full, dec_full;

    // Bit WIDTH of each extended result is the carry (or borrow) out.
    assign add_full = {1'b0, w_q} + {1'b0, b};
    assign adc_full = add_full + {{WIDTH{1'b0}}, c_q};
    assign sub_full = {1'b0, w_q} - {1'b0, b};
    assign inc_full = {1'b0, w_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_full = {1'b0, w_q} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_w  = w_q;
        alu_c  = c_q;
        alu_wr = 1'b0;
        case (inst)
            OpLoad: begin alu_w = b;                      alu_wr = 1'b1; end
            OpAdd:  begin {alu_c, alu_w} = add_full;      alu_wr = 1'b1; end
            OpSub:  begin {alu_c, alu_w} = sub_full;      alu_wr = 1'b1; end
            OpAnd:  begin alu_w = w_q & b;                alu_wr = 1'b1; end
            OpOr:   begin alu_w = w_q | b;                alu_wr = 1'b1; end
            OpXor:  begin alu_w = w_q ^ b;                alu_wr = 1'b1; end
            OpNot:  begin alu_w = ~w_q;                   alu_wr = 1'b1; end
            OpShl:  begin alu_c = w_q[WIDTH-1]; alu_w = w_q << 1; alu_wr = 1'b1; end
            OpShr:  begin alu_c = w_q[0];       alu_w = w_q >> 1; alu_wr = 1'b1; end
            OpAdc:  begin {alu_c, alu_w} = adc_full;      alu_wr = 1'b1; end
            OpInc:  begin {alu_c, alu_w} = inc_full;      alu_wr = 1'b1; end
            OpDec:  begin {alu_c, alu_w} = dec_full;      alu_wr = 1'b1; end
            OpClrc: alu_c = 1'b0;
            default: ;
        endcase
    end

`ifdef EXEC_UNIT_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OpMul = 4'd12;

    typedef enum logic {StIdle, StMul} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   prod_nx;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     h_q, h_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 accept, mul_start, mul_fin;

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q == StMul);
    assign h          = h_q;
    assign accept     = in_valid && in_ready;
    assign mul_start  = accept && (inst == OpMul);
    assign single_acc = accept && (inst != OpMul);
    assign mul_fin    = (state_q == StMul) && (cnt_q == CW'(1));
    assign prod_nx    = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        h_d      = h_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (mul_start) begin
                    state_d  = StMul;
                    mcand_d  = {{WIDTH{1'b0}}, b};
                    mplier_d = w_q;
                    prod_d   = '0;
                    cnt_d    = CW'(WIDTH);
                end
            end
            StMul: begin
                prod_d   = prod_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (mul_fin) begin
                    state_d = StIdle;
                    h_d     = prod_nx[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            h_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            h_q      <= h_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign in_ready   = 1'b1;
    assign busy       = 1'b0;
    assign h          = '0;
    assign single_acc = in_valid;
`endif

    always_comb begin
        w_d    = w_q;
        c_d    = c_q;
        z_d    = z_q;
        done_d = 1'b0;
`ifdef EXEC_UNIT_MUL_EN
        if (mul_fin) begin
            w_d    = prod_nx[WIDTH-1:0];
            c_d    = |prod_nx[2*WIDTH-1:WIDTH];
            z_d    = ~|prod_nx[WIDTH-1:0];
            done_d = 1'b1;
        end else
`endif
        if (single_acc) begin
            done_d = 1'b1;
            c_d    = alu_c;
            if (alu_wr) begin
                w_d = alu_w;
                z_d = ~|alu_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q    <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b1;
            done_q <= 1'b0;
        end else begin
            w_q    <= w_d;
            c_q    <= c_d;
            z_q    <= z_d;
            done_q <= done_d;
        end
    end

    assign w     = w_q;
    assign carry = c_q;
    assign zero  = z_q;
    assign done  = done_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: an 8-bit instance for the main function
// and a 16-bit instance for the width regression.
module tb_exec_unit;

    localparam logic [3:0] LOAD = 4'd0,  ADD = 4'd1,  SUB = 4'd2,  AND_ = 4'd3;
    localparam logic [3:0] OR_  = 4'd4,  XOR_ = 4'd5, NOT_ = 4'd6, SHL = 4'd7;
    localparam logic [3:0] SHR  = 4'd8,  ADC = 4'd9,  INC = 4'd10, DEC = 4'd11;
    localparam logic [3:0] MUL  = 4'd12, CLRC = 4'd13, NOP = 4'd14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  inst8, inst16;
    logic [7:0]  b8;
    logic [15:0] b16;
    logic        v8, v16;

    logic        rdy8, busy8, done8, c8, z8;
    logic [7:0]  w8, h8;
    logic        rdy16, busy16, done16, c16, z16;
    logic [15:0] w16, h16;

    int n_cmp  = 0;
    int n_fail = 0;

    exec_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .inst(inst8), .b(b8), .in_valid(v8),
        .in_ready(rdy8), .busy(busy8), .done(done8), .w(w8), .h(h8),
        .carry(c8), .zero(z8)
    );

    exec_unit #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .inst(inst16), .b(b16), .in_valid(v16),
        .in_ready(rdy16), .busy(busy16), .done(done16), .w(w16), .h(h16),
        .carry(c16), .zero(z16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd8(input logic [3:0] op, input logic [7:0] val);
        inst8 = op;
        b8    = val;
        v8    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        v8 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd16(input logic [3:0] op, input logic [15:0] val);
        inst16 = op;
        b16    = val;
        v16    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; v8 = 1'b0; v16 = 1'b0;
        inst8 = '0; b8 = '0; inst16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_w", w8, 8'h00);
        chk("rst_h", h8, 8'h00);
        chk("rst_carry", c8, 1'b0);
        chk("rst_zero", z8, 1'b1);
        chk("rst_ready", rdy8, 1'b1);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        idle8();
        chk("post_rst_done", done8, 1'b0);

        // Carry chain, issued back to back
        cmd8(LOAD, 8'd250);
        chk("load_w", w8, 8'd250);
        chk("load_done", done8, 1'b1);
        cmd8(ADD, 8'd10);
        chk("add_w", w8, 8'd4);
        chk("add_c", c8, 1'b1);
        chk("add_done", done8, 1'b1);
        cmd8(ADC, 8'd3);
        chk("adc_w", w8, 8'd8);
        chk("adc_c", c8, 1'b0);
        cmd8(SUB, 8'd9);
        chk("sub_w", w8, 8'd255);
        chk("sub_c", c8, 1'b1);
        chk("sub_z", z8, 1'b0);
        idle8();
        chk("idle_done", done8, 1'b0);
        chk("idle_w", w8, 8'd255);

        // Shifts and logic
        cmd8(LOAD, 8'h81);
        chk("load81_c_hold", c8, 1'b1);
        cmd8(SHL, 8'h00);
        chk("shl_w", w8, 8'h02);
        chk("shl_c", c8, 1'b1);
        cmd8(SHR, 8'h00);
        chk("shr_w", w8, 8'h01);
        chk("shr_c", c8, 1'b0);
        cmd8(XOR_, 8'h01);
        chk("xor_w", w8, 8'h00);
        chk("xor_z", z8, 1'b1);
        cmd8(DEC, 8'h00);
        chk("dec_w", w8, 8'hFF);
        chk("dec_c", c8, 1'b1);
        chk("dec_z", z8, 1'b0);
        cmd8(LOAD, 8'h80);
        cmd8(SHR, 8'h00);
        chk("shr_logical", w8, 8'h40);
        cmd8(LOAD, 8'hF0);
        cmd8(AND_, 8'h3C);
        chk("and_w", w8, 8'h30);
        cmd8(OR_, 8'h0F);
        chk("or_w", w8, 8'h3F);
        cmd8(NOT_, 8'h00);
        chk("not_w", w8, 8'hC0);
        cmd8(INC, 8'h00);
        chk("inc_w", w8, 8'hC1);
        chk("inc_c", c8, 1'b0);
        cmd8(LOAD, 8'hFF);
        cmd8(INC, 8'h00);
        chk("inc_wrap_w", w8, 8'h00);
        chk("inc_wrap_c", c8, 1'b1);
        chk("inc_wrap_z", z8, 1'b1);
        cmd8(CLRC, 8'h00);
        chk("clrc_c", c8, 1'b0);
        chk("clrc_z", z8, 1'b1);
        chk("clrc_done", done8, 1'b1);
        cmd8(LOAD, 8'd9);
        cmd8(SUB, 8'd9);
        chk("sub_eq_w", w8, 8'd0);
        chk("sub_eq_c", c8, 1'b0);
        chk("sub_eq_z", z8, 1'b1);
        cmd8(LOAD, 8'h5A);
        cmd8(NOP, 8'h55);
        chk("nop_w", w8, 8'h5A);
        chk("nop_done", done8, 1'b1);

        // Mid-stream reset
        cmd8(LOAD, 8'hFF);
        cmd8(ADD, 8'd2);
        chk("pre_rst_c", c8, 1'b1);
        v8 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mrst_w", w8, 8'h00);
        chk("mrst_c", c8, 1'b0);
        chk("mrst_z", z8, 1'b1);
        chk("mrst_ready", rdy8, 1'b1);
        chk("mrst_done", done8, 1'b0);

`ifdef EXEC_UNIT_MUL_EN
        cmd8(LOAD, 8'd200);
        cmd8(MUL, 8'd3);
        chk("mul_busy", busy8, 1'b1);
        chk("mul_ready", rdy8, 1'b0);
        chk("mul_nodone", done8, 1'b0);
        // Held command must wait until the multiply finishes
        inst8 = LOAD;
        b8    = 8'h11;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("mul_busy_hold", busy8, 1'b1);
            chk("mul_w_hold", w8, 8'd200);
            chk("mul_done_low", done8, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("mul_w", w8, 8'h58);
        chk("mul_h", h8, 8'h02);
        chk("mul_c", c8, 1'b1);
        chk("mul_z", z8, 1'b0);
        chk("mul_done", done8, 1'b1);
        chk("mul_busy_fall", busy8, 1'b0);
        @(posedge clk);
        #1;
        chk("after_mul_w", w8, 8'h11);
        chk("after_mul_h", h8, 8'h02);
        chk("after_mul_done", done8, 1'b1);

        cmd8(LOAD, 8'd15);
        cmd8(MUL, 8'd15);
        v8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mul2_busy", busy8, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mulrst_w", w8, 8'h00);
        chk("mulrst_h", h8, 8'h00);
        chk("mulrst_c", c8, 1'b0);
        chk("mulrst_z", z8, 1'b1);
        chk("mulrst_busy", busy8, 1'b0);
        chk("mulrst_ready", rdy8, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("mulrst_no_done", done8, 1'b0);
        end
`else
        cmd8(LOAD, 8'd7);
        cmd8(MUL, 8'd5);
        chk("nomul_done", done8, 1'b1);
        chk("nomul_w", w8, 8'd7);
        chk("nomul_h", h8, 8'h00);
        chk("nomul_busy", busy8, 1'b0);
        chk("nomul_ready", rdy8, 1'b1);
        chk("nomul_z", z8, 1'b0);
        idle8();
        chk("nomul_done_fall", done8, 1'b0);
        chk("nomul_busy2", busy8, 1'b0);
`endif

        // 16-bit width regression
        cmd16(LOAD, 16'hFFFF);
        chk("w16_load", w16, 16'hFFFF);
        cmd16(ADD, 16'h0001);
        chk("w16_add_w", w16, 16'h0000);
        chk("w16_add_c", c16, 1'b1);
        chk("w16_add_z", z16, 1'b1);
        chk("w16_done", done16, 1'b1);
        chk("w16_h", h16, 16'h0000);
        v16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execution unit: a WIDTH-bit working register (W), carry and zero flags, and an ALU with a valid/ready command handshake. It sits between the program counter/decoder and the data path. It generalises the fixed 8-bit ALU + W register pair with a configurable width, an add-with-carry, and a multi-cycle shift-add multiplier that produces a high-half register (H).

## Interface
- WIDTH, 8, data path width in bits; legal range 4..32.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- inst  input  4  opcode; sampled on accept.
- b  input  WIDTH  second operand; sampled on accept.
- in_valid  input  1  a command is present on inst/b.
- in_ready  output  1  unit can accept a command; equals !busy.
- busy  output  1  a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse when a command's results are visible.
- w  output  WIDTH  working register.
- h  output  WIDTH  high half of the last MUL; otherwise unchanged.
- carry  output  1  carry/borrow flag.
- zero  output  1  set when the last write to W produced 0.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready. When in_ready=0, inst and b are ignored and not queued.
- Opcodes (W=w, C=carry; arithmetic is modulo 2^WIDTH, carry taken from bit WIDTH of a WIDTH+1-bit result):
  - 0 LOAD: W=b; C unchanged.
  - 1 ADD: W=W+b; C=carry out.
  - 2 SUB: W=W-b; C=1 iff W<b (unsigned borrow).
  - 3 AND, 4 OR, 5 XOR with b; C unchanged.
  - 6 NOT: W=~W; C unchanged.
  - 7 SHL: C=W[MSB]; W=W<<1.
  - 8 SHR: C=W[0]; W=W>>1 (logical).
  - 9 ADC: W=W+b+C; C=carry out.
  - 10 INC: W=W+1; C=carry out.
  - 11 DEC: W=W-1; C=1 iff W was 0.
  - 12 MUL: {H,W}=W*b (unsigned); C=1 iff H≠0.
  - 13 CLRC: C=0.
  - 14, 15 NOP: no state change.
- zero is updated on every op that writes W (0–12); otherwise it holds.
- FSM: IDLE → (accept MUL) → MUL → IDLE. All other opcodes complete in IDLE.
- MUL uses a shift-add over WIDTH iterations, one multiplier bit per cycle. A counter of $clog2(WIDTH+1) bits runs from WIDTH down to 0. The operands are latched on accept; W, H and the flags are written only on the final cycle.

## Timing
- Reset (any state, including mid-MUL): W=0, H=0, carry=0, zero=1, busy=0, in_ready=1, done=0, FSM=IDLE. Any partial product is discarded.
- Single-cycle ops:
  - Accepted at edge N; results and done=1 are visible after edge N.
  - in_ready stays 1, so back-to-back accepts are allowed every cycle. Each accept produces its own done pulse.
- MUL:
  - Accepted at edge N; busy=1 and in_ready=0 from after edge N.
  - Final results and done=1 appear after edge N+WIDTH.
  - busy falls in the same cycle done rises, so the next accept is possible at edge N+WIDTH+1. Total latency is WIDTH cycles.
  - During MUL, w/h/carry/zero hold their pre-MUL values.
- in_valid held high while in_ready=0 is harmless; the command is accepted at the first edge where in_ready=1.
- done is never asserted during reset or on the cycle after reset.

## Configuration
- EXEC_UNIT_MUL_EN defined: MUL (opcode 12), the MUL FSM state and the H register are built as above.
- Not defined:
  - Opcode 12 behaves as NOP: single cycle, done pulse, no state change.
  - h is tied to 0, busy is tied to 0 and in_ready is tied to 1.
  - No multiplier logic is synthesised.

## Test plan
- Reset: assert reset for 1 cycle mid-stream → w=0, h=0, carry=0, zero=1, in_ready=1, done=0.
- WIDTH=8, carry chain: LOAD 250; ADD 10 → w=4, carry=1; ADC 3 → w=8, carry=0; SUB 9 → w=255, carry=1, zero=0.
- WIDTH=8, shifts/logic: LOAD 0x81; SHL → w=0x02, carry=1; SHR → w=0x01, carry=0; XOR 0x01 → w=0, zero=1; DEC → w=255, carry=1.
- WIDTH=8 with MUL_EN: LOAD 200; MUL 3 → busy for 8 cycles, in_valid ignored meanwhile, then w=0x58, h=0x02, carry=1, done for one cycle; next command accepted on the following edge.
- Reset asserted 4 cycles into MUL 15×15 → all outputs at reset values; no done pulse.
- Without MUL_EN: LOAD 7; MUL 5 → done after 1 cycle, w=7, h=0, busy never rises; WIDTH=16 regression of ADD 0xFFFF+1 → w=0, carry=1, zero=1.
